// File: rtl/regfile_dumper_pkg.sv
// Shared types and constants for the register-file dumper.
package regfile_dump_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_HDR,
    ST_SEND,
    ST_DONE
  } dump_state_t;

  localparam int         BYTES_PER_REG = 4;
  localparam logic [2:0] HDR_PREFIX    = 3'b000;
endpackage

// File: rtl/regfile_dumper_if.sv
// Register-file read port plus start/status and byte-stream handshake of the dumper.
interface regfile_dumper_if;
  logic        start;
  logic        busy;
  logic        done;
  logic        rd_en;
  logic [4:0]  rd_index;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;

  modport master (
    input  start, rd_data, out_ready,
    output busy, done, rd_en, rd_index, out_valid, out_data
  );

  modport slave (
    output start, rd_data, out_ready,
    input  busy, done, rd_en, rd_index, out_valid, out_data
  );
endinterface

// File: rtl/regfile_dumper_serializer.sv
// Holds one captured 32-bit word and shifts it out low byte first; flags the final byte.
module dump_byte_serializer
  import regfile_dump_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        shift,
  output logic [7:0]  byte_out,
  output logic        last
);
  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (load) begin
      word_d = load_data;
      cnt_d  = 2'd0;
    end else if (shift) begin
      word_d = word_q >> 8;
      cnt_d  = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign byte_out = word_q[7:0];
  assign last     = (cnt_q == 2'(BYTES_PER_REG - 1));
endmodule

// File: rtl/regfile_dumper.sv
// Walks register indices FIRST_REG..LAST_REG and streams each word out as bytes.
// Define REGDUMP_HEADER_EN to prefix each register with a {3'b000, index} header byte.
module regfile_dumper
  import regfile_dump_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic             clk,
  input  logic             reset,
  regfile_dumper_if.master bus
);
  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  dump_state_t state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic        hs, ser_load, ser_shift, ser_last;
  logic [7:0]  ser_byte;

  assign hs = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: if (bus.start) begin
        idx_d   = FIRST_IDX;
        state_d = ST_READ;
      end
`ifdef REGDUMP_HEADER_EN
      ST_READ: state_d = ST_HDR;
      ST_HDR:  if (hs) state_d = ST_SEND;
`else
      ST_READ: state_d = ST_SEND;
`endif
      ST_SEND: if (hs && ser_last) begin
        // idx stops at LAST_IDX so the index never wraps
        if (idx_q == LAST_IDX) state_d = ST_DONE;
        else begin
          idx_d   = idx_q + 5'd1;
          state_d = ST_READ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state_q != ST_IDLE);
    bus.done      = (state_q == ST_DONE);
    bus.rd_en     = (state_q == ST_READ);
    bus.rd_index  = idx_q;
    bus.out_valid = (state_q == ST_SEND) || (state_q == ST_HDR);
    bus.out_data  = (state_q == ST_HDR) ? {HDR_PREFIX, idx_q} : ser_byte;
    ser_load      = (state_q == ST_READ);
    ser_shift     = (state_q == ST_SEND) && hs;
  end

  dump_byte_serializer u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (ser_load),
    .load_data (bus.rd_data),
    .shift     (ser_shift),
    .byte_out  (ser_byte),
    .last      (ser_last)
  );
endmodule

// File: tb/tb_regfile_dumper.sv
// Scoreboard bench: three dumper instances (0..31, 1..2, 31..31) share clock and reset.
module tb_regfile_dumper;
`ifdef REGDUMP_HEADER_EN
  localparam bit HDR = 1'b1;
  localparam int CPR = 6;
`else
  localparam bit HDR = 1'b0;
  localparam int CPR = 5;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_dumper_if if_full ();
  regfile_dumper_if if_small ();
  regfile_dumper_if if_one ();

  regfile_dumper #(.FIRST_REG(0), .LAST_REG(31)) u_full  (.clk(clk), .reset(rst), .bus(if_full));
  regfile_dumper #(.FIRST_REG(1), .LAST_REG(2))  u_small (.clk(clk), .reset(rst), .bus(if_small));
  regfile_dumper #(.FIRST_REG(31), .LAST_REG(31)) u_one  (.clk(clk), .reset(rst), .bus(if_one));

  function automatic logic [31:0] rf(input logic [4:0] i);
    case (i)
      5'd1:    rf = 32'hDEADBEEF;
      5'd2:    rf = 32'h01234567;
      5'd5:    rf = 32'hA5A55A5A;
      5'd31:   rf = 32'h000000FF;
      default: rf = 32'h0;
    endcase
  endfunction

  logic [2:0] st, rdy;
  logic [2:0] v, dn, re, bs;
  logic [7:0] d [3];
  logic [4:0] ri [3];

  assign if_full.start  = st[0];  assign if_full.out_ready  = rdy[0];
  assign if_small.start = st[1];  assign if_small.out_ready = rdy[1];
  assign if_one.start   = st[2];  assign if_one.out_ready   = rdy[2];
  assign if_full.rd_data  = rf(if_full.rd_index);
  assign if_small.rd_data = rf(if_small.rd_index);
  assign if_one.rd_data   = rf(if_one.rd_index);

  assign v  = {if_one.out_valid, if_small.out_valid, if_full.out_valid};
  assign dn = {if_one.done, if_small.done, if_full.done};
  assign re = {if_one.rd_en, if_small.rd_en, if_full.rd_en};
  assign bs = {if_one.busy, if_small.busy, if_full.busy};
  assign d[0] = if_full.out_data;  assign d[1] = if_small.out_data;  assign d[2] = if_one.out_data;
  assign ri[0] = if_full.rd_index; assign ri[1] = if_small.rd_index; assign ri[2] = if_one.rd_index;

  int n_cmp = 0;
  int n_err = 0;

  task automatic cmp(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] got %0h expected %0h (t=%0t)", nm, k, act, exp, $time);
    end
  endtask

  logic [7:0] q0[$], q1[$], q2[$];

  task automatic push_b(input int k, input logic [7:0] b);
    case (k)
      0:       q0.push_back(b);
      1:       q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  function automatic int qsize(input int k);
    case (k)
      0:       qsize = q0.size();
      1:       qsize = q1.size();
      default: qsize = q2.size();
    endcase
  endfunction

  task automatic push_reg(input int k, input logic [4:0] i);
    logic [31:0] w;
    w = rf(i);
    if (HDR) push_b(k, {3'b000, i});
    for (int b = 0; b < 4; b++) push_b(k, w[8*b +: 8]);
  endtask

  // Directed expectation for registers 1..2: EF BE AD DE 67 45 23 01
  task automatic push_small();
    if (HDR) push_b(1, 8'h01);
    push_b(1, 8'hEF); push_b(1, 8'hBE); push_b(1, 8'hAD); push_b(1, 8'hDE);
    if (HDR) push_b(1, 8'h02);
    push_b(1, 8'h67); push_b(1, 8'h45); push_b(1, 8'h23); push_b(1, 8'h01);
  endtask

  int done_cnt[3], done_cyc[3], first_v_cyc[3], hs_cnt[3], exp_rd[3];
  bit first_v_seen[3];
  bit prev_stall[3];
  logic [7:0] prev_data[3];

  // Monitor: pops the scoreboard on every handshake and checks hold/rd_index/done.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) prev_stall[k] = 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (prev_stall[k]) begin
          cmp("hold_valid", k, 32'(v[k]), 32'd1);
          cmp("hold_data", k, 32'(d[k]), 32'(prev_data[k]));
        end
        if (v[k] && !first_v_seen[k]) begin
          first_v_seen[k] = 1'b1;
          first_v_cyc[k]  = cyc;
        end
        if (v[k] && rdy[k]) begin
          if (qsize(k) == 0) cmp("extra_byte", k, 32'(d[k]), 32'hFFFF_FFFF);
          else begin
            logic [7:0] e;
            case (k)
              0:       e = q0.pop_front();
              1:       e = q1.pop_front();
              default: e = q2.pop_front();
            endcase
            cmp("byte", k, 32'(d[k]), 32'(e));
          end
          hs_cnt[k]++;
        end
        if (re[k]) begin
          cmp("rd_index", k, 32'(ri[k]), 32'(exp_rd[k] & 31));
          exp_rd[k]++;
        end
        if (dn[k]) begin
          done_cnt[k]++;
          done_cyc[k] = cyc;
        end
        prev_stall[k] = v[k] && !rdy[k];
        prev_data[k]  = d[k];
      end
    end
  end

  bit stall_mode = 1'b0;
  int stall_left = 0;
  always @(posedge clk) begin
    if (stall_mode) begin
      #1;
      if (hs_cnt[1] == (HDR ? 3 : 2) && stall_left > 0) begin
        rdy[1] = 1'b0;
        stall_left--;
      end else rdy[1] = 1'($urandom_range(0, 1));
    end
  end

  int start_cyc[3];

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(input int k);
    hs_cnt[k] = 0;
    first_v_seen[k] = 1'b0;
    tick();
    st[k] = 1'b1;
    start_cyc[k] = cyc;
    tick();
    st[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int base, input int budget);
    int n;
    n = 0;
    while (done_cnt[k] == base && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt[k] == base) cmp("timeout", k, 32'd1, 32'd0);
  endtask

  int base;

  initial begin
    st  = '0;
    rdy = '1;
    for (int k = 0; k < 3; k++) begin
      done_cnt[k] = 0; hs_cnt[k] = 0; exp_rd[k] = 0; first_v_seen[k] = 1'b0;
    end
    repeat (3) tick();
    cmp("rst_busy", 0, 32'(if_full.busy), 32'd0);
    cmp("rst_done", 0, 32'(if_full.done), 32'd0);
    cmp("rst_rd_en", 0, 32'(if_full.rd_en), 32'd0);
    cmp("rst_rd_index", 0, 32'(if_full.rd_index), 32'd0);
    cmp("rst_valid", 0, 32'(if_full.out_valid), 32'd0);
    cmp("rst_data", 0, 32'(if_full.out_data), 32'd0);
    rst = 1'b0;
    tick();

    // Registers 1..2 with a free-running sink
    push_small();
    exp_rd[1] = 1;
    base = done_cnt[1];
    do_start(1);
    cmp("busy_after_start", 1, 32'(bs[1]), 32'd1);
    wait_done(1, base, 100);
    cmp("small_done_lat", 1, 32'(done_cyc[1] - start_cyc[1]), 32'(2 * CPR + 1));
    cmp("small_first_valid", 1, 32'(first_v_cyc[1] - start_cyc[1]), 32'd2);
    tick();
    cmp("small_busy_low", 1, 32'(bs[1]), 32'd0);
    cmp("small_done_once", 1, 32'(done_cnt[1] - base), 32'd1);
    cmp("small_q_empty", 1, 32'(qsize(1)), 32'd0);
    repeat (3) tick();

    // Same dump against a random sink with a 7-cycle stall on byte AD
    push_small();
    exp_rd[1] = 1;
    base = done_cnt[1];
    hs_cnt[1] = 0;
    stall_left = 7;
    stall_mode = 1'b1;
    do_start(1);
    wait_done(1, base, 400);
    stall_mode = 1'b0;
    tick();
    rdy[1] = 1'b1;
    cmp("stall_q_empty", 1, 32'(qsize(1)), 32'd0);
    cmp("stall_used", 1, 32'(stall_left), 32'd0);
    cmp("stall_done_once", 1, 32'(done_cnt[1] - base), 32'd1);
    repeat (3) tick();

    // Full default dump 0..31
    for (int i = 0; i < 32; i++) push_reg(0, 5'(i));
    exp_rd[0] = 0;
    base = done_cnt[0];
    do_start(0);
    wait_done(0, base, 400);
    cmp("full_done_lat", 0, 32'(done_cyc[0] - start_cyc[0]), 32'(32 * CPR + 1));
    cmp("full_first_valid", 0, 32'(first_v_cyc[0] - start_cyc[0]), 32'd2);
    cmp("full_rd_sweep", 0, 32'(exp_rd[0]), 32'd32);
    cmp("full_q_empty", 0, 32'(qsize(0)), 32'd0);
    repeat (3) tick();

    // start re-asserted while busy and while in DONE
    push_small();
    exp_rd[1] = 1;
    base = done_cnt[1];
    do_start(1);
    tick();
    st[1] = 1'b1;
    repeat (2) tick();
    st[1] = 1'b0;
    wait_done(1, base, 100);
    st[1] = 1'b1;
    tick();
    st[1] = 1'b0;
    repeat (20) tick();
    cmp("restart_done_once", 1, 32'(done_cnt[1] - base), 32'd1);
    cmp("restart_q_empty", 1, 32'(qsize(1)), 32'd0);
    cmp("restart_busy_low", 1, 32'(bs[1]), 32'd0);

    // Reset during SEND of x5, then a clean dump
    for (int i = 0; i < 32; i++) push_reg(0, 5'(i));
    exp_rd[0] = 0;
    base = done_cnt[0];
    do_start(0);
    begin
      int n;
      n = 0;
      while (!(re[0] && ri[0] == 5'd5) && n < 100) begin
        tick();
        n++;
      end
      if (n >= 100) cmp("timeout_x5", 0, 32'd1, 32'd0);
    end
    tick();
    if (HDR) tick();
    cmp("x5_sending", 0, 32'(v[0]), 32'd1);
    #1 rst = 1'b1;
    #1;
    cmp("rst_async_valid", 0, 32'(v[0]), 32'd0);
    cmp("rst_async_busy", 0, 32'(bs[0]), 32'd0);
    q0.delete();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    cmp("rst_no_done", 0, 32'(done_cnt[0] - base), 32'd0);
    for (int i = 0; i < 32; i++) push_reg(0, 5'(i));
    exp_rd[0] = 0;
    base = done_cnt[0];
    do_start(0);
    wait_done(0, base, 400);
    cmp("redump_rd_sweep", 0, 32'(exp_rd[0]), 32'd32);
    cmp("redump_q_empty", 0, 32'(qsize(0)), 32'd0);
    repeat (3) tick();

    // Single register: FIRST=LAST=31
    if (HDR) push_b(2, 8'h1F);
    push_b(2, 8'hFF); push_b(2, 8'h00); push_b(2, 8'h00); push_b(2, 8'h00);
    exp_rd[2] = 31;
    base = done_cnt[2];
    do_start(2);
    wait_done(2, base, 50);
    repeat (5) tick();
    cmp("one_done_lat", 2, 32'(done_cyc[2] - start_cyc[2]), 32'(CPR + 1));
    cmp("one_rd_count", 2, 32'(exp_rd[2]), 32'd32);
    cmp("one_done_once", 2, 32'(done_cnt[2] - base), 32'd1);
    cmp("one_q_empty", 2, 32'(qsize(2)), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
